// File: rtl/prog_mod_cntr.sv
// Programmable-modulus up/down counter with IDLE/RUN/DONE control FSM.
// Supports one-shot or free-running passes, synchronous load and run-time modulus writes.
module prog_mod_cntr #(
    parameter int unsigned W       = 4,
    parameter int unsigned MOD_DEF = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         oneshot_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         mod_wr_i,
    input  logic [W-1:0] mod_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o,
    output logic         wrap_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         mod_err_o
);

    localparam logic [W-1:0] ModDef = W'(MOD_DEF);
    localparam logic [W-1:0] ModMin = W'(2);
    localparam logic [W-1:0] One    = W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] mod_q;
    logic         oneshot_q;
    logic         wrap_q;
    logic         mod_err_q;

    logic         mod_ok;
    logic         mod_bad;
    logic [W-1:0] eff_mod;
    logic         load_bad;
    logic [W-1:0] mod_last;
    logic [W-1:0] term;
    logic         at_term;
    logic         step;
    logic         wrap_now;

    always_comb begin
        mod_ok   = mod_wr_i && (mod_val_i >= ModMin);
        mod_bad  = mod_wr_i && (mod_val_i < ModMin);
        eff_mod  = mod_ok ? mod_val_i : mod_q;
        load_bad = load_i && (load_val_i >= eff_mod);
        mod_last = mod_q - One;
        term     = up_i ? mod_last : '0;
        at_term  = (cnt_q == term);
        // An accepted modulus write owns cnt this cycle, so no step happens alongside it.
        step     = (state_q == StRun) && en_i && !load_i && !mod_ok;
        wrap_now = step && at_term;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mod_q     <= ModDef;
            oneshot_q <= 1'b0;
            wrap_q    <= 1'b0;
            mod_err_q <= 1'b0;
        end else begin
            wrap_q    <= wrap_now;
            mod_err_q <= mod_bad || load_bad;

            if (mod_ok) begin
                mod_q <= mod_val_i;
            end

            if (load_i) begin
                cnt_q <= load_bad ? '0 : load_val_i;
            end else if (mod_ok) begin
                if (cnt_q >= mod_val_i) begin
                    cnt_q <= '0;
                end
            end else if (step) begin
                if (at_term) begin
                    cnt_q <= up_i ? '0 : mod_last;
                end else begin
                    cnt_q <= up_i ? (cnt_q + One) : (cnt_q - One);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StRun;
                        oneshot_q <= oneshot_i;
                    end
                end
                StRun: begin
                    if (stop_i) begin
                        state_q <= StIdle;
                    end else if (wrap_now && oneshot_q) begin
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cnt_o     = cnt_q;
    assign tc_o      = (state_q == StRun) && at_term;
    assign wrap_o    = wrap_q;
    assign busy_o    = (state_q == StRun);
    assign done_o    = (state_q == StDone);
    assign mod_err_o = mod_err_q;

endmodule

// File: tb/tb_prog_mod_cntr.sv
// Self-checking bench for prog_mod_cntr: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model of the counter.
module tb_prog_mod_cntr;

    localparam int unsigned W = 4;

    localparam int PIdle = 0;
    localparam int PRun  = 1;
    localparam int PDone = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, up, start, stop, oneshot, load, mod_wr;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] cnt;
    logic         tc, wrap, busy, done, mod_err;

    always #5 clk = ~clk;

    prog_mod_cntr #(.W(W), .MOD_DEF(10)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .up_i       (up),
        .start_i    (start),
        .stop_i     (stop),
        .oneshot_i  (oneshot),
        .load_i     (load),
        .load_val_i (load_val),
        .mod_wr_i   (mod_wr),
        .mod_val_i  (mod_val),
        .cnt_o      (cnt),
        .tc_o       (tc),
        .wrap_o     (wrap),
        .busy_o     (busy),
        .done_o     (done),
        .mod_err_o  (mod_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_cnt;
    int m_mod;
    int m_ph;
    bit m_os;
    bit m_wrap;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_mod  = 10;
        m_ph   = PIdle;
        m_os   = 1'b0;
        m_wrap = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int term;
        term = up ? m_mod - 1 : 0;
        chk({tag, ".cnt"},     32'(cnt),     32'(m_cnt));
        chk({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
        chk({tag, ".busy"},    32'(busy),    32'(m_ph == PRun));
        chk({tag, ".done"},    32'(done),    32'(m_ph == PDone));
        chk({tag, ".mod_err"}, 32'(mod_err), 32'(m_err));
        chk({tag, ".tc"},      32'(tc),      32'((m_ph == PRun) && (m_cnt == term)));
    endtask

    task automatic idle_inputs();
        en = 0; up = 0; start = 0; stop = 0; oneshot = 0;
        load = 0; load_val = '0; mod_wr = 0; mod_val = '0;
    endtask

    // Predict the next state from the current inputs, clock once, then compare.
    task automatic step(input string tag);
        int  n_cnt, n_ph, eff, lv, mv;
        bit  n_os, n_wrap, n_err, ok;
        lv     = int'(load_val);
        mv     = int'(mod_val);
        ok     = mod_wr && (mv >= 2);
        eff    = ok ? mv : m_mod;
        n_err  = (mod_wr && !ok) || (load && (lv >= eff));
        n_cnt  = m_cnt;
        n_ph   = m_ph;
        n_os   = m_os;
        n_wrap = 1'b0;
        if (load) begin
            n_cnt = (lv >= eff) ? 0 : lv;
        end else if (ok) begin
            if (m_cnt >= mv) n_cnt = 0;
        end else if (m_ph == PRun && en) begin
            if (up) begin
                if (m_cnt == m_mod - 1) begin n_cnt = 0; n_wrap = 1'b1; end
                else n_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin n_cnt = m_mod - 1; n_wrap = 1'b1; end
                else n_cnt = m_cnt - 1;
            end
        end
        case (m_ph)
            PIdle: if (start) begin n_ph = PRun; n_os = oneshot; end
            PRun: begin
                if (stop) n_ph = PIdle;
                else if (n_wrap && m_os) n_ph = PDone;
            end
            default: n_ph = PIdle;
        endcase
        @(posedge clk);
        #1;
        m_cnt  = n_cnt;
        m_mod  = eff;
        m_ph   = n_ph;
        m_os   = n_os;
        m_wrap = n_wrap;
        m_err  = n_err;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Free-running count with the default modulus
        start = 1; oneshot = 0; up = 1; en = 1;
        step("r036");
        start = 0;
        chk("r036.first", 32'(cnt), 0);
        for (int i = 1; i < 25; i++) begin
            step("r036");
            chk("r036.seq",  32'(cnt),  32'(i % 10));
            chk("r036.wrap", 32'(wrap), 32'(i % 10 == 0));
            chk("r036.busy", 32'(busy), 1);
        end

        // Modulus shrink below cnt, then a rejected write
        repeat (4) step("run");
        chk("r037.pre", 32'(cnt), 8);
        mod_wr = 1; mod_val = 6;
        step("r037.wr");
        mod_wr = 0;
        chk("r037.clr", 32'(cnt), 0);
        mod_wr = 1; mod_val = 1;
        step("r037.rej");
        mod_wr = 0;
        chk("r037.err", 32'(mod_err), 1);
        repeat (5) step("r037.cnt");
        chk("r037.wrap6", 32'(wrap), 1);
        chk("r037.cnt6",  32'(cnt),  0);

        // One-shot down-count pass
        stop = 1;
        step("r038.stop");
        stop = 0;
        chk("r038.idle", 32'(busy), 0);
        up = 0; oneshot = 1; load = 1; load_val = 3;
        step("r038.load");
        load = 0;
        chk("r038.loaded", 32'(cnt), 3);
        start = 1;
        step("r038.start");
        start = 0;
        step("r038.c2");
        step("r038.c1");
        step("r038.c0");
        chk("r038.tc0", 32'(tc), 1);
        step("r038.wrap");
        chk("r038.cnt5", 32'(cnt),  5);
        chk("r038.done", 32'(done), 1);
        chk("r038.busy", 32'(busy), 0);
        step("r038.back");
        chk("r038.hold", 32'(cnt),  5);
        chk("r038.ndone", 32'(done), 0);
        step("r038.hold2");

        // Simultaneous load and modulus write with load_val at the new modulus
        load = 1; load_val = 7; mod_wr = 1; mod_val = 7;
        step("r039");
        load = 0; mod_wr = 0;
        chk("r039.cnt", 32'(cnt),     0);
        chk("r039.err", 32'(mod_err), 1);
        up = 1; oneshot = 0; start = 1;
        step("r039.start");
        start = 0;
        repeat (7) step("r039.run");
        chk("r039.wrap7", 32'(wrap), 1);

        // Asynchronous reset in the middle of a pass
        repeat (4) step("r040.run");
        chk("r040.pre", 32'(cnt), 4);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("r040.async");
        @(negedge clk);
        rst = 1'b0;
        start = 1;
        step("r040.start");
        start = 0;
        chk("r040.busy", 32'(busy), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            oneshot  = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 11) == 0);
            load_val = W'($urandom_range(0, 15));
            mod_wr   = ($urandom_range(0, 15) == 0);
            mod_val  = W'($urandom_range(0, 15));
            step("rand");
        end
        idle_inputs();
        step("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_mod_cntr.md
PROG_MOD_CNTR -- requirements
Module: prog_mod_cntr

Interface
REQ-001 Parameter W, default 4: counter and modulus width in bits; legal range 2..16.
REQ-002 Parameter MOD_DEF, default 10: modulus loaded at reset; legal range 2..2^W-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 en  input  1  count enable; the counter steps only in RUN with en=1.
REQ-006 up  input  1  direction, sampled every cycle: 1 = increment, 0 = decrement.
REQ-007 start  input  1  single-cycle request to leave IDLE and enter RUN.
REQ-008 stop  input  1  single-cycle request to leave RUN and return to IDLE.
REQ-009 oneshot  input  1  mode, captured on the cycle start is accepted: 1 = single pass, 0 = free-running.
REQ-010 load  input  1  synchronous load of load_val into cnt.
REQ-011 load_val  input  W  load value.
REQ-012 mod_wr  input  1  synchronous write of mod_val into the modulus register.
REQ-013 mod_val  input  W  new modulus.
REQ-014 cnt  output  W  registered count value.
REQ-015 tc  output  1  terminal-count flag; combinational from registered state.
REQ-016 wrap  output  1  registered one-cycle pulse on each wrap.
REQ-017 busy  output  1  high in RUN only.
REQ-018 done  output  1  registered one-cycle pulse; high in DONE only.
REQ-019 mod_err  output  1  registered one-cycle pulse on a rejected write or a clamped load.

Function
REQ-020 Count range SHALL be 0..mod_reg-1; cnt SHALL never hold a value >= mod_reg.
REQ-021 Terminal value SHALL be mod_reg-1 when up=1 and 0 when up=0.
REQ-022 tc SHALL equal (state==RUN) and (cnt==terminal), independent of en.
REQ-023 In RUN with en=1, cnt SHALL step by one, with no latency beyond the clock edge; at terminal it SHALL wrap (up: to 0; down: to mod_reg-1), and wrap SHALL be high in the cycle cnt shows the wrapped value.
REQ-024 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->IDLE on stop.
- RUN->DONE on a wrap with captured oneshot=1.
- DONE->IDLE unconditionally after one cycle.
REQ-025 start SHALL be ignored in RUN and DONE; stop SHALL be ignored in IDLE and DONE; stop together with a wrap SHALL go to IDLE, with the wrap still performed and pulsed.
REQ-026 cnt SHALL hold in IDLE and DONE, except when loaded.
REQ-027 mod_wr with mod_val < 2 SHALL be rejected: mod_reg unchanged, mod_err pulse.
REQ-028 An accepted mod_wr SHALL update mod_reg at the next edge; if cnt >= new modulus (and no load that cycle), cnt SHALL become 0 at the same edge.
REQ-029 load SHALL act in any state without changing state and SHALL take priority over stepping that cycle; no wrap pulse is generated by a load.
REQ-030 load_val >= the effective modulus SHALL load 0 and pulse mod_err. The effective modulus is the new one if an accepted mod_wr occurs in the same cycle, otherwise mod_reg.
REQ-031 Update priority SHALL be: rst, then load/mod_wr, then count step.
REQ-032 Arithmetic SHALL be W bits wide, with no overflow beyond the W-bit range at any modulus up to 2^W-1.

Reset
REQ-033 rst assertion SHALL immediately set state=IDLE, cnt=0, mod_reg=MOD_DEF, captured oneshot=0, and wrap=done=mod_err=0; busy=0 and tc=0 follow.
REQ-034 rst mid-RUN SHALL abort the pass with no wrap or done pulse.
REQ-035 Leaving reset SHALL require no start-up cycles; start is accepted on the first edge after rst deasserts.

Verification
REQ-036 Defaults, start with oneshot=0, up=1, en=1 for 25 cycles -> cnt 0..9,0..9,0..4; wrap at each 9->0; busy=1 throughout.
REQ-037 mod_wr with mod_val=6 while cnt=8 -> next cycle mod_reg=6 and cnt=0; mod_val=1 -> mod_err pulse, modulus unchanged.
REQ-038 oneshot=1, up=0, load 3, start -> cnt 3,2,1,0,5 (mod 6) with wrap; then DONE for one cycle (done=1, busy=0); then IDLE with cnt held at 5.
REQ-039 Simultaneous load=1 with load_val=7 and mod_wr=1 with mod_val=7 -> mod_reg=7, cnt=0, mod_err pulse.
REQ-040 Assert rst asynchronously mid-RUN at cnt=4 -> outputs reset before the next edge; no done pulse; start on the first edge after release is accepted.
